opc_req_queue: RTL and testbench
================================

# opc_req_queue

Operand-request queue and register-bank read scheduler for the operand-collector (OC) stage. It sits directly downstream of the issue-side parallel control, which resolves each instruction's two source operands into bank/row pairs and picks a free collector unit. This block buffers those two-operand requests in order and drives per-bank read enables/rows to the four register banks. It tags every issued read with the destination collector and operand slot, and serialises bank conflicts within a request.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- ROW_W, 3, row index width
- BANK_W, 2, bank index width (4 banks)
- OC_W, 2, collector id width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- ReqFIFO_2op_EN  in  1  push a two-operand request this cycle
- rowid_a  in  ROW_W  operand A row
- bankid_a  in  BANK_W  operand A bank
- rowid_b  in  ROW_W  operand B row
- bankid_b  in  BANK_W  operand B bank
- ocid_IU_OC  in  OC_W  destination collector
- rd_hold  in  1  downstream back-pressure; suppresses issue this cycle
- req_full  out  1  count == DEPTH
- req_empty  out  1  count == 0
- bank_rd_en  out  4  per-bank read enable, registered
- bank_rd_row  out  4*ROW_W  bank k row at [ROW_W*k +: ROW_W], registered
- grant_valid  out  1  a read was issued this cycle, registered
- grant_ocid  out  OC_W  collector receiving the data, registered
- grant_opmask  out  2  bit0 = operand A served, bit1 = operand B served, registered

## Operation
- Entry = {ocid, row_a, bank_a, row_b, bank_b}. Circular buffer: wr_ptr, rd_ptr mod DEPTH, count 0..DEPTH.
- Push: when ReqFIFO_2op_EN=1 and req_full=0, write inputs at wr_ptr, advance wr_ptr. A push while req_full=1 is dropped, even if a pop occurs the same edge. No state changes.
- In-order service: only the head entry is issued.
- Head FSM, 2 states:
  - HEAD_NEW (both operands pending). With the head valid and rd_hold=0:
    - bank_a≠bank_b: issue both reads; opmask=11; pop; stay HEAD_NEW.
    - bank_a==bank_b, row_a==row_b: one read on that bank (broadcast); opmask=11; pop; stay HEAD_NEW.
    - bank_a==bank_b, row_a≠row_b: issue A only; opmask=01; go to HEAD_B_ONLY.
  - HEAD_B_ONLY. With rd_hold=0: issue B; opmask=10; pop; go to HEAD_NEW.
- rd_hold=1 or FIFO empty: no issue. bank_rd_en=0, grant_valid=0, grant_opmask=0, FSM unchanged.
- Issue outputs:
  - Rows of non-enabled banks are driven 0.
  - grant_ocid holds the issued entry's ocid and is 0 when grant_valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: the entry is eligible at the next edge. There is no same-cycle bypass.

## Timing
- Reset (rst=0 at an edge) clears count, pointers, FSM→HEAD_NEW and all registered outputs to 0. req_empty=1, req_full=0.
- Reset mid-operation discards all queued entries and any pending B operand.
- Latency: a request pushed at edge E gets its first issue on bank_rd_en after edge E+1, provided the FIFO was empty and rd_hold=0.
- Throughput: one request per cycle without conflict; a conflicting request takes 2 cycles.
- req_full/req_empty are decoded combinationally from the registered count.
- Bank data returns one cycle after bank_rd_en. The OC latches it using the grant_* values it captured with the read.

## Test plan
- Reset: hold rst=0 for 2 edges with pushes active -> all outputs 0, req_empty=1, no entries retained.
- No conflict: push oc=1, A=(row2,bank0), B=(row5,bank3) -> next cycle bank_rd_en=1001, bank0 row=2, bank3 row=5, grant_ocid=1, opmask=11; then req_empty=1.
- Conflict: push oc=3, A=(1,bank2), B=(4,bank2) -> cycle 1: en=0100, row=1, opmask=01. Cycle 2: en=0100, row=4, opmask=10, pop. Cycle 3: grant_valid=0.
- Broadcast: push oc=2, A=B=(6,bank1) -> a single cycle with en=0010, row=6, opmask=11.
- Full/back-pressure: rd_hold=1, push oc=0,1,2,3,0 on consecutive cycles -> req_full=1 after the 4th push, 5th dropped. Release rd_hold -> exactly 4 grants with ocid 0,1,2,3 in order, then req_empty=1.
- Reset mid-conflict: after the A issue of a conflicting request, assert rst=0 -> next edge all outputs 0, B never issued, req_empty=1.

Source files
------------

// File: rtl/opc_req_queue.sv
// Operand-request queue: buffers two-operand bank/row requests in order and
// schedules register-bank reads, splitting same-bank/different-row pairs over two cycles.
module opc_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ROW_W  = 3,
  parameter int BANK_W = 2,
  parameter int OC_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ReqFIFO_2op_EN,
  input  logic [ROW_W-1:0]     rowid_a,
  input  logic [BANK_W-1:0]    bankid_a,
  input  logic [ROW_W-1:0]     rowid_b,
  input  logic [BANK_W-1:0]    bankid_b,
  input  logic [OC_W-1:0]      ocid_IU_OC,
  input  logic                 rd_hold,
  output logic                 req_full,
  output logic                 req_empty,
  output logic [3:0]           bank_rd_en,
  output logic [4*ROW_W-1:0]   bank_rd_row,
  output logic                 grant_valid,
  output logic [OC_W-1:0]      grant_ocid,
  output logic [1:0]           grant_opmask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NBANK = 4;

  localparam logic [0:0] HEAD_NEW    = 1'b0;
  localparam logic [0:0] HEAD_B_ONLY = 1'b1;

  logic [OC_W-1:0]   oc_mem     [DEPTH];
  logic [ROW_W-1:0]  row_a_mem  [DEPTH];
  logic [BANK_W-1:0] bank_a_mem [DEPTH];
  logic [ROW_W-1:0]  row_b_mem  [DEPTH];
  logic [BANK_W-1:0] bank_b_mem [DEPTH];

  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [0:0]             state_reg, state_next;
  logic [NBANK-1:0]       en_reg, en_next;
  logic [NBANK*ROW_W-1:0] row_reg, row_next;
  logic                   gv_reg;
  logic [OC_W-1:0]        goc_reg, goc_next;
  logic [1:0]             mask_reg;

  logic              push, pop, issue, serve_a, serve_b, conflict;
  logic [OC_W-1:0]   head_oc;
  logic [ROW_W-1:0]  head_row_a, head_row_b;
  logic [BANK_W-1:0] head_bank_a, head_bank_b;

  assign req_full  = (count_reg == CNT_W'(DEPTH));
  assign req_empty = (count_reg == '0);

  assign head_oc     = oc_mem[rd_ptr_reg];
  assign head_row_a  = row_a_mem[rd_ptr_reg];
  assign head_bank_a = bank_a_mem[rd_ptr_reg];
  assign head_row_b  = row_b_mem[rd_ptr_reg];
  assign head_bank_b = bank_b_mem[rd_ptr_reg];

  assign push     = ReqFIFO_2op_EN && !req_full;
  assign issue    = !req_empty && !rd_hold;
  assign conflict = (head_bank_a == head_bank_b) && (head_row_a != head_row_b);
  // A is served only on the first visit; B is served unless it has to wait for a second cycle.
  assign serve_a  = issue && (state_reg == HEAD_NEW);
  assign serve_b  = issue && ((state_reg == HEAD_B_ONLY) || !conflict);
  assign pop      = serve_b;

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign goc_next   = issue ? head_oc : '0;

  always_comb begin
    state_next = state_reg;
    if (issue)
      state_next = ((state_reg == HEAD_NEW) && conflict) ? HEAD_B_ONLY : HEAD_NEW;
  end

  // Per-bank decode; a same-bank same-row pair lights one bank for both operands.
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      logic hit_a, hit_b;
      assign hit_a = serve_a && (head_bank_a == BANK_W'(gi));
      assign hit_b = serve_b && (head_bank_b == BANK_W'(gi));
      assign en_next[gi] = hit_a || hit_b;
      assign row_next[gi*ROW_W +: ROW_W] = hit_a ? head_row_a :
                                           hit_b ? head_row_b : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      oc_mem[wr_ptr_reg]     <= ocid_IU_OC;
      row_a_mem[wr_ptr_reg]  <= rowid_a;
      bank_a_mem[wr_ptr_reg] <= bankid_a;
      row_b_mem[wr_ptr_reg]  <= rowid_b;
      bank_b_mem[wr_ptr_reg] <= bankid_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= HEAD_NEW;
      en_reg     <= '0;
      row_reg    <= '0;
      gv_reg     <= 1'b0;
      goc_reg    <= '0;
      mask_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      state_reg <= state_next;
      en_reg    <= en_next;
      row_reg   <= row_next;
      gv_reg    <= issue;
      goc_reg   <= goc_next;
      mask_reg  <= {serve_b, serve_a};
    end
  end

  assign bank_rd_en   = en_reg;
  assign bank_rd_row  = row_reg;
  assign grant_valid  = gv_reg;
  assign grant_ocid   = goc_reg;
  assign grant_opmask = mask_reg;

endmodule

// File: tb/tb_opc_req_queue.sv
// Directed table-driven bench for opc_req_queue: each vector drives one cycle of
// inputs and lists the outputs expected just after that clock edge.
module tb_opc_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_en;
  logic [2:0]  rowid_a, rowid_b;
  logic [1:0]  bankid_a, bankid_b;
  logic [1:0]  ocid;
  logic        rd_hold;
  logic        req_full, req_empty;
  logic [3:0]  bank_rd_en;
  logic [11:0] bank_rd_row;
  logic        grant_valid;
  logic [1:0]  grant_ocid;
  logic [1:0]  grant_opmask;

  always #5 clk = ~clk;

  opc_req_queue #(.DEPTH(4), .ROW_W(3), .BANK_W(2), .OC_W(2)) dut (
    .clk(clk), .rst(rst), .ReqFIFO_2op_EN(push_en),
    .rowid_a(rowid_a), .bankid_a(bankid_a), .rowid_b(rowid_b), .bankid_b(bankid_b),
    .ocid_IU_OC(ocid), .rd_hold(rd_hold),
    .req_full(req_full), .req_empty(req_empty),
    .bank_rd_en(bank_rd_en), .bank_rd_row(bank_rd_row),
    .grant_valid(grant_valid), .grant_ocid(grant_ocid), .grant_opmask(grant_opmask)
  );

  typedef struct {
    logic        rst_n;
    logic        push;
    logic [2:0]  ra;
    logic [1:0]  ba;
    logic [2:0]  rb;
    logic [1:0]  bb;
    logic [1:0]  oc;
    logic        hold;
    logic [3:0]  en;
    logic [11:0] rows;
    logic        gv;
    logic [1:0]  goc;
    logic [1:0]  mask;
    logic        full;
    logic        empty;
  } vec_t;

  vec_t vecs[28];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s actual=%h required=%h", idx, name, act, exp);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst_n; push_en = v.push; rowid_a = v.ra; bankid_a = v.ba;
    rowid_b = v.rb; bankid_b = v.bb; ocid = v.oc; rd_hold = v.hold;
    @(posedge clk);
    #1;
    $display("vec%0d rst=%b push=%b hold=%b -> en=%b rows=%h gv=%b oc=%0d mask=%b full=%b empty=%b",
             idx, v.rst_n, v.push, v.hold, bank_rd_en, bank_rd_row, grant_valid,
             grant_ocid, grant_opmask, req_full, req_empty);
    chk("bank_rd_en",   idx, 12'(bank_rd_en),   12'(v.en));
    chk("bank_rd_row",  idx, bank_rd_row,       v.rows);
    chk("grant_valid",  idx, 12'(grant_valid),  12'(v.gv));
    chk("grant_ocid",   idx, 12'(grant_ocid),   12'(v.goc));
    chk("grant_opmask", idx, 12'(grant_opmask), 12'(v.mask));
    chk("req_full",     idx, 12'(req_full),     12'(v.full));
    chk("req_empty",    idx, 12'(req_empty),    12'(v.empty));
  endtask

  initial begin
    rst = 1'b0; push_en = 1'b0; rowid_a = '0; bankid_a = '0;
    rowid_b = '0; bankid_b = '0; ocid = '0; rd_hold = 1'b0;

    //          rst   push  ra    ba    rb    bb    oc    hold  en       rows     gv    goc   mask   full  empty
    // reset held two edges with pushes active
    vecs[0]  = '{1'b0, 1'b1, 3'd2, 2'd0, 3'd5, 2'd3, 2'd1, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'd2, 2'd0, 3'd5, 2'd3, 2'd1, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    // no conflict: bank0 row2, bank3 row5
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 2'd0, 3'd5, 2'd3, 2'd1, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b1001, 12'hA02, 1'b1, 2'd1, 2'b11, 1'b0, 1'b1};
    // conflict on bank2: row1 then row4
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 2'd2, 3'd4, 2'd2, 2'd3, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0100, 12'h040, 1'b1, 2'd3, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0100, 12'h100, 1'b1, 2'd3, 2'b10, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    // broadcast: bank1 row6 for both operands
    vecs[8]  = '{1'b1, 1'b1, 3'd6, 2'd1, 3'd6, 2'd1, 2'd2, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0010, 12'h030, 1'b1, 2'd2, 2'b11, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    // fill under back-pressure; fifth push dropped
    vecs[11] = '{1'b1, 1'b1, 3'd0, 2'd0, 3'd1, 2'd1, 2'd0, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 2'd2, 3'd3, 2'd3, 2'd1, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'd4, 2'd0, 3'd5, 2'd1, 2'd2, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 3'd6, 2'd2, 3'd7, 2'd3, 2'd3, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 3'd7, 2'd1, 3'd7, 2'd2, 2'd0, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b1, 1'b0};
    // drain; push while full with a pop on the same edge is still dropped
    vecs[16] = '{1'b1, 1'b1, 3'd2, 2'd0, 3'd3, 2'd1, 2'd1, 1'b0, 4'b0011, 12'h008, 1'b1, 2'd0, 2'b11, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b1100, 12'h680, 1'b1, 2'd1, 2'b11, 1'b0, 1'b0};
    // simultaneous push and pop keeps the count
    vecs[18] = '{1'b1, 1'b1, 3'd1, 2'd0, 3'd2, 2'd1, 2'd2, 1'b0, 4'b0011, 12'h02C, 1'b1, 2'd2, 2'b11, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b1100, 12'hF80, 1'b1, 2'd3, 2'b11, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0011, 12'h011, 1'b1, 2'd2, 2'b11, 1'b0, 1'b1};
    // hold on a waiting head
    vecs[21] = '{1'b1, 1'b1, 3'd3, 2'd3, 3'd3, 2'd3, 2'd1, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b1000, 12'h600, 1'b1, 2'd1, 2'b11, 1'b0, 1'b1};
    // hold between the A and B halves of a conflict
    vecs[24] = '{1'b1, 1'b1, 3'd5, 2'd1, 3'd7, 2'd1, 2'd2, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0010, 12'h028, 1'b1, 2'd2, 2'b01, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0010, 12'h038, 1'b1, 2'd2, 2'b10, 1'b0, 1'b1};

    for (int i = 0; i < 28; i++) step(i, vecs[i]);

    // Reset right after the A half of a conflict: B must never appear.
    step(100, '{1'b1, 1'b1, 3'd1, 2'd2, 3'd4, 2'd2, 2'd3, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0});
    step(101, '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0100, 12'h040, 1'b1, 2'd3, 2'b01, 1'b0, 1'b0});
    step(102, '{1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1});
    step(103, '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1});
    step(104, '{1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 12'h000, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
